// File: rtl/tt_um_jleugeri_token_pkg.sv
// Shared types for the token event recorder: record kind, token state and record layout.
// Optional length measurement is enabled by defining TOKEN_RECORDER_LENGTH_EN.
package tt_um_jleugeri_token_pkg;

    typedef enum logic {
        KIND_START = 1'b0,
        KIND_END   = 1'b1
    } rec_kind_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ON   = 1'b1
    } token_state_t;

    localparam int REC_TIME_BITS   = 8;
    localparam int REC_LENGTH_BITS = 8;

    // Field order (kind, time, length) is the packing used for every FIFO word, MSB first.
    typedef struct packed {
        rec_kind_t                   kind;
        logic [REC_TIME_BITS-1:0]    tstamp;
        logic [REC_LENGTH_BITS-1:0]  length;
    } token_record_t;

endpackage

// File: rtl/tt_um_jleugeri_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module tt_um_jleugeri_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is masked while empty so stale storage never appears on the outputs.
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/tt_um_jleugeri_token_event_recorder.sv
// Timestamps token start/end pulses into a record FIFO and flags protocol errors and drops.
// Define TOKEN_RECORDER_LENGTH_EN to measure the on-length carried by end records.
module tt_um_jleugeri_token_event_recorder
    import tt_um_jleugeri_token_pkg::*;
#(
    parameter int TIMESTAMP_BITS = 8,
    parameter int LENGTH_BITS    = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          token_start,
    input  logic                          token_end,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic                          rec_kind,
    output logic [TIMESTAMP_BITS-1:0]     rec_time,
    output logic [LENGTH_BITS-1:0]        rec_length,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          protocol_error,
    input  logic                          clear_errors
);

    localparam int REC_W = 1 + TIMESTAMP_BITS + LENGTH_BITS;

    token_state_t              state_reg;
    token_state_t              state_next;
    logic [TIMESTAMP_BITS-1:0] ts_reg;
    logic [LENGTH_BITS-1:0]    length_value;
    logic                      push;
    rec_kind_t                 push_kind;
    logic                      perr_set;
    logic                      restart_len;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic [REC_W-1:0]          push_data;
    logic [REC_W-1:0]          pop_data;
    logic                      overflow_reg;
    logic                      perr_reg;

    always_comb begin
        state_next  = state_reg;
        push        = 1'b0;
        push_kind   = KIND_START;
        perr_set    = 1'b0;
        restart_len = 1'b0;
        if (token_start && token_end) begin
            perr_set = 1'b1;
        end else if (token_start) begin
            // A start while already on is flagged but still recorded as a fresh start.
            push        = 1'b1;
            restart_len = 1'b1;
            state_next  = ST_ON;
            perr_set    = (state_reg == ST_ON);
        end else if (token_end) begin
            if (state_reg == ST_ON) begin
                push       = 1'b1;
                push_kind  = KIND_END;
                state_next = ST_IDLE;
            end else begin
                perr_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            ts_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ts_reg    <= ts_reg + 1'b1;
        end
    end

`ifdef TOKEN_RECORDER_LENGTH_EN
    logic [LENGTH_BITS-1:0] len_reg;

    // len_reg equals cycles elapsed since the accepted start, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg <= '0;
        end else if (restart_len) begin
            len_reg <= LENGTH_BITS'(1);
        end else if (state_next == ST_IDLE) begin
            len_reg <= '0;
        end else if (len_reg != '1) begin
            len_reg <= len_reg + 1'b1;
        end
    end

    assign length_value = (push_kind == KIND_END) ? len_reg : '0;
`else
    assign length_value = '0;
`endif

    assign push_data = {push_kind, ts_reg, length_value};
    assign rec_valid = !empty;
    assign pop       = rec_valid && rec_ready;

    tt_um_jleugeri_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign {rec_kind, rec_time, rec_length} = pop_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
            perr_reg     <= 1'b0;
        end else if (clear_errors) begin
            overflow_reg <= 1'b0;
            perr_reg     <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                overflow_reg <= 1'b1;
            end
            if (perr_set) begin
                perr_reg <= 1'b1;
            end
        end
    end

    assign overflow       = overflow_reg;
    assign protocol_error = perr_reg;

endmodule
